// File: rtl/pixel_shade_pkg.sv
// Shared shading modes, face factors and colour helpers for pixel_shade_pipe.
// Face factors are 8.8 fixed point, so 256 means "unchanged".
package pixel_shade_pkg;

  typedef enum logic [1:0] {
    SHADE_FLAT  = 2'd0,
    SHADE_FACE  = 2'd1,
    SHADE_FOG   = 2'd2,
    SHADE_DEPTH = 2'd3
  } shade_mode_e;

  localparam logic [8:0] FACE_K_X = 9'd256;
  localparam logic [8:0] FACE_K_Y = 9'd192;
  localparam logic [8:0] FACE_K_Z = 9'd128;

  localparam int RGB_COLOR_W = 8;

  typedef struct packed {
    logic [RGB_COLOR_W-1:0] r;
    logic [RGB_COLOR_W-1:0] g;
    logic [RGB_COLOR_W-1:0] b;
  } rgb_t;

  // Reserved face code shades like an x face.
  function automatic logic [8:0] face_k(input logic [1:0] dir);
    case (dir)
      2'd1:    return FACE_K_Y;
      2'd2:    return FACE_K_Z;
      default: return FACE_K_X;
    endcase
  endfunction

endpackage

// File: rtl/shade_blend_ch.sv
// One colour channel of stages 2 and 3: face multiply, then fog/depth/miss select.
// Holds its registers whenever en is low, so the channel stalls with the pipe.
module shade_blend_ch
  import pixel_shade_pkg::*;
#(
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         s1_mode,
  input  logic [8:0]         s1_k,
  input  logic [COLOR_W-1:0] s1_c,
  input  logic [COLOR_W-1:0] s1_fog,
  input  logic [COLOR_W-1:0] s1_sky,
  input  logic               s2_hit,
  input  logic [1:0]         s2_mode,
  input  logic [7:0]         s2_f,
  output logic [COLOR_W-1:0] out_c
);

  localparam int IW = COLOR_W + 9;

  shade_mode_e m1, m2;
  logic [COLOR_W-1:0] c2_q, c2_d, fog2_q, fog2_d, sky2_q, sky2_d, out_q, out_d;
  logic [IW-1:0] face_prod, blend;

  assign m1 = shade_mode_e'(s1_mode);
  assign m2 = shade_mode_e'(s2_mode);

  always_comb begin
    c2_d   = c2_q;
    fog2_d = fog2_q;
    sky2_d = sky2_q;
    face_prod = IW'(s1_c) * IW'(s1_k);
    if (en) begin
      fog2_d = s1_fog;
      sky2_d = s1_sky;
      if (m1 == SHADE_FACE || m1 == SHADE_FOG) c2_d = COLOR_W'(face_prod >> 8);
      else                                     c2_d = s1_c;
    end
  end

  // Weights sum to 256, so the blend never exceeds the channel maximum.
  always_comb begin
    out_d = out_q;
    blend = IW'(c2_q) * IW'(9'd256 - 9'(s2_f)) + IW'(fog2_q) * IW'(s2_f);
    if (en) begin
      if (!s2_hit) begin
        out_d = (m2 == SHADE_DEPTH) ? '0 : sky2_q;
      end else begin
        case (m2)
          SHADE_FOG:   out_d = COLOR_W'(blend >> 8);
          SHADE_DEPTH: out_d = COLOR_W'(8'd255 - s2_f);
          default:     out_d = c2_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c2_q   <= '0;
      fog2_q <= '0;
      sky2_q <= '0;
      out_q  <= '0;
    end else begin
      c2_q   <= c2_d;
      fog2_q <= fog2_d;
      sky2_q <= sky2_d;
      out_q  <= out_d;
    end
  end

  assign out_c = out_q;

endmodule

// File: rtl/pixel_shade_pipe.sv
// Three-stage pixel shader with fog, depth debug and hit/miss counters; 3-cycle latency.
// All stages advance together only when the output slot is empty or being taken.
module pixel_shade_pipe
  import pixel_shade_pkg::*;
#(
  parameter int COLOR_W   = 8,
  parameter int T_W       = 16,
  parameter int TAG_W     = 21,
  parameter int FOG_SHIFT = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [1:0]           mode_in,
  input  logic [3*COLOR_W-1:0] fog_rgb_in,
  input  logic [3*COLOR_W-1:0] sky_rgb_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_hit,
  input  logic [1:0]           in_dir,
  input  logic [3*COLOR_W-1:0] in_mat_rgb,
  input  logic [T_W-1:0]       in_t,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*COLOR_W-1:0] out_rgb,
  output logic [TAG_W-1:0]     out_tag,
  input  logic                 clear_in,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count
);

  localparam int RGB_W = 3 * COLOR_W;

  logic en;
  logic [T_W-1:0] t_sh;

  logic v1_q, v1_d, hit1_q, hit1_d;
  logic [1:0] mode1_q, mode1_d;
  logic [RGB_W-1:0] mat1_q, mat1_d, fog1_q, fog1_d, sky1_q, sky1_d;
  logic [7:0] f1_q, f1_d;
  logic [8:0] k1_q, k1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  logic v2_q, v2_d, hit2_q, hit2_d;
  logic [1:0] mode2_q, mode2_d;
  logic [7:0] f2_q, f2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  logic v3_q, v3_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;

  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  assign en       = !v3_q || out_ready;
  assign in_ready = en;

  always_comb begin
    v1_d = v1_q;  hit1_d = hit1_q;  mode1_d = mode1_q;  mat1_d = mat1_q;
    fog1_d = fog1_q;  sky1_d = sky1_q;  f1_d = f1_q;  k1_d = k1_q;  tag1_d = tag1_q;
    v2_d = v2_q;  hit2_d = hit2_q;  mode2_d = mode2_q;  f2_d = f2_q;  tag2_d = tag2_q;
    v3_d = v3_q;  tag3_d = tag3_q;
    t_sh = in_t >> FOG_SHIFT;
    if (en) begin
      v1_d    = in_valid;
      hit1_d  = in_hit;
      mode1_d = mode_in;
      mat1_d  = in_mat_rgb;
      fog1_d  = fog_rgb_in;
      sky1_d  = sky_rgb_in;
      f1_d    = (t_sh > T_W'(255)) ? 8'hFF : t_sh[7:0];
      k1_d    = face_k(in_dir);
      tag1_d  = in_tag;

      v2_d    = v1_q;
      hit2_d  = hit1_q;
      mode2_d = mode1_q;
      f2_d    = f1_q;
      tag2_d  = tag1_q;

      v3_d    = v2_q;
      tag3_d  = tag2_q;
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (clear_in) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (in_valid && en) begin
      if (in_hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end else begin
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      v1_q <= 1'b0;  hit1_q <= 1'b0;  mode1_q <= '0;  mat1_q <= '0;
      fog1_q <= '0;  sky1_q <= '0;  f1_q <= '0;  k1_q <= '0;  tag1_q <= '0;
      v2_q <= 1'b0;  hit2_q <= 1'b0;  mode2_q <= '0;  f2_q <= '0;  tag2_q <= '0;
      v3_q <= 1'b0;  tag3_q <= '0;
      hit_cnt_q <= '0;  miss_cnt_q <= '0;
    end else begin
      v1_q <= v1_d;  hit1_q <= hit1_d;  mode1_q <= mode1_d;  mat1_q <= mat1_d;
      fog1_q <= fog1_d;  sky1_q <= sky1_d;  f1_q <= f1_d;  k1_q <= k1_d;  tag1_q <= tag1_d;
      v2_q <= v2_d;  hit2_q <= hit2_d;  mode2_q <= mode2_d;  f2_q <= f2_d;  tag2_q <= tag2_d;
      v3_q <= v3_d;  tag3_q <= tag3_d;
      hit_cnt_q <= hit_cnt_d;  miss_cnt_q <= miss_cnt_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    shade_blend_ch #(.COLOR_W(COLOR_W)) u_ch (
      .clk     (clk_in),
      .rst_n   (rst_in),
      .en      (en),
      .s1_mode (mode1_q),
      .s1_k    (k1_q),
      .s1_c    (mat1_q[i*COLOR_W +: COLOR_W]),
      .s1_fog  (fog1_q[i*COLOR_W +: COLOR_W]),
      .s1_sky  (sky1_q[i*COLOR_W +: COLOR_W]),
      .s2_hit  (hit2_q),
      .s2_mode (mode2_q),
      .s2_f    (f2_q),
      .out_c   (out_rgb[i*COLOR_W +: COLOR_W])
    );
  end

  assign out_valid  = v3_q;
  assign out_tag    = tag3_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_pixel_shade_pipe.sv
// Scoreboard bench for pixel_shade_pipe: directed test-plan pixels plus randomized traffic.
module tb_pixel_shade_pipe;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic [1:0]  mode_in = '0;
  logic [23:0] fog_rgb_in = '0, sky_rgb_in = '0;
  logic        in_valid = 1'b0, in_hit = 1'b0;
  logic        in_ready;
  logic [1:0]  in_dir = '0;
  logic [23:0] in_mat_rgb = '0;
  logic [15:0] in_t = '0;
  logic [20:0] in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_rgb;
  logic [20:0] out_tag;
  logic        clear_in = 1'b0;
  logic [31:0] hit_count, miss_count;

  int checks = 0;
  int errors = 0;
  logic [44:0] exp_q[$];
  logic [20:0] tagc = 21'h100;

  bit          stall_prev = 0;
  logic [23:0] stall_rgb;
  logic [20:0] stall_tag;

  always #5 clk = ~clk;

  pixel_shade_pipe dut (
    .clk_in(clk), .rst_in(rst_in), .mode_in(mode_in),
    .fog_rgb_in(fog_rgb_in), .sky_rgb_in(sky_rgb_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_hit(in_hit), .in_dir(in_dir),
    .in_mat_rgb(in_mat_rgb), .in_t(in_t), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgb(out_rgb), .out_tag(out_tag),
    .clear_in(clear_in), .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shading computed straight from the per-pixel rules with integer arithmetic.
  function automatic logic [23:0] ref_shade(input bit hit, input int mode, input int dir,
                                            input logic [23:0] mat, input logic [23:0] fog,
                                            input logic [23:0] sky, input int t);
    int f, k, c, fc, r;
    logic [23:0] res;
    f = t / 16;
    if (f > 255) f = 255;
    k = (dir == 1) ? 192 : ((dir == 2) ? 128 : 256);
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      c  = int'(mat[ch*8 +: 8]);
      fc = int'(fog[ch*8 +: 8]);
      if (!hit)           r = (mode == 3) ? 0 : int'(sky[ch*8 +: 8]);
      else if (mode == 0) r = c;
      else if (mode == 1) r = c * k / 256;
      else if (mode == 2) r = ((c * k / 256) * (256 - f) + fc * f) / 256;
      else                r = 255 - f;
      res[ch*8 +: 8] = r[7:0];
    end
    return res;
  endfunction

  // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input bit hit, input logic [1:0] mode, input logic [1:0] dir,
                      input logic [23:0] mat, input logic [15:0] t, input logic [20:0] tag,
                      input logic [23:0] exp);
    int waitc = 0;
    bit acc = 0;
    in_valid = 1'b1; in_hit = hit; mode_in = mode; in_dir = dir;
    in_mat_rgb = mat; in_t = t; in_tag = tag;
    while (!acc && waitc < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      waitc++;
    end
    chk("accept", acc, 1);
    if (acc) exp_q.push_back({exp, tag});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit hit);
    logic [1:0] m, d;
    logic [23:0] mat;
    logic [15:0] t;
    m   = 2'($urandom_range(0, 3));
    d   = 2'($urandom_range(0, 3));
    mat = 24'($urandom);
    t   = 16'($urandom_range(0, 5000));
    tagc++;
    send(hit, m, d, mat, t, tagc, ref_shade(hit, int'(m), int'(d), mat, fog_rgb_in, sky_rgb_in, int'(t)));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [44:0] e;
    if (!rst_in) begin
      stall_prev = 0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (stall_prev && out_valid) begin
        chk("stall_rgb", out_rgb, stall_rgb);
        chk("stall_tag", out_tag, stall_tag);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_tag, 21'h0);
          chk("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("out_tag", out_tag, e[20:0]);
          chk("out_rgb", out_rgb, e[44:21]);
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_rgb  = out_rgb;
      stall_tag  = out_tag;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, stale;
    bit rand_done;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rgb", out_rgb, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_in = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Flat shading with latency measurement.
    fog_rgb_in = 24'hFFFFFF;
    sky_rgb_in = 24'h0A141E;
    send(1, 2'd0, 2'd1, 24'hC86432, 16'h0010, 21'h0ABCD, 24'hC86432);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
    drain();

    // Remaining test-plan pixels, back to back.
    send(1, 2'd1, 2'd2, 24'hC86432, 16'h0010, 21'h00001, 24'h643219);
    send(1, 2'd1, 2'd1, 24'hC86432, 16'h0010, 21'h00002, 24'h964B25);
    send(1, 2'd2, 2'd0, 24'hC86432, 16'h0800, 21'h00003, 24'hE3B198);
    send(1, 2'd2, 2'd0, 24'hC86432, 16'hFFFF, 21'h00004, 24'hFEFEFE);
    send(0, 2'd2, 2'd0, 24'hC86432, 16'h0800, 21'h00005, 24'h0A141E);
    send(1, 2'd3, 2'd0, 24'hC86432, 16'h0100, 21'h00006, 24'hEFEFEF);
    drain();
    chk("plan_hit_count", hit_count, 6);
    chk("plan_miss_count", miss_count, 1);

    // Six pixels back to back with the consumer stalled mid-burst.
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand(1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Statistics and clear.
    clear_in = 1'b1;
    @(posedge clk); #1;
    clear_in = 1'b0;
    chk("clr_hit", hit_count, 0);
    chk("clr_miss", miss_count, 0);
    for (int i = 0; i < 5; i++) send_rand(1'b1);
    for (int i = 0; i < 2; i++) send_rand(1'b0);
    drain();
    chk("stat_hit_5", hit_count, 5);
    chk("stat_miss_2", miss_count, 2);
    clear_in = 1'b1;
    send_rand(1'b1);
    clear_in = 1'b0;
    chk("clr_win_hit", hit_count, 0);
    chk("clr_win_miss", miss_count, 0);
    send_rand(1'b0);
    drain();
    chk("post_clr_miss", miss_count, 1);
    chk("post_clr_hit", hit_count, 0);

    // Randomized traffic with random backpressure and changing fog/sky.
    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          fog_rgb_in = 24'($urandom);
          sky_rgb_in = 24'($urandom);
          send_rand($urandom_range(0, 3) != 0);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with three pixels in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(1'b1);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_rgb", out_rgb, 0);
    chk("arst_hit_count", hit_count, 0);
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst_in = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("arst_no_stale", stale, 0);
    @(posedge clk); #1;
    send_rand(1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_shade_pipe.md
# pixel_shade_pipe

Parametrised, back-pressured successor to the single-pixel colour stage. Takes per-pixel hit results from the ray/block intersection stage (hit flag, face direction, material colour, distance t, pixel tag). Produces shaded RGB through a fixed 3-stage pipeline with a selectable shading mode, distance fog and hit/miss statistics. Sits between intersection and the frame-buffer writer.

## Interface
- COLOR_W, 8, bits per colour channel (in and out)
- T_W, 16, unsigned integer distance width
- TAG_W, 21, sideband tag width ({x[10:0], y[9:0]}), passed through untouched
- FOG_SHIFT, 4, right shift applied to t to form fog weight
- CNT_W, 32, statistics counter width
- clk_in  in  1  clock
- rst_in  in  1  reset; asynchronous, active-low
- mode_in  in  2  0 flat, 1 face-shaded, 2 face+fog, 3 depth debug; sampled with each accepted pixel
- fog_rgb_in  in  3*COLOR_W  fog colour {r,g,b}; quasi-static
- sky_rgb_in  in  3*COLOR_W  colour for misses; quasi-static
- in_valid  in  1  input pixel valid
- in_ready  out  1  stage can accept
- in_hit  in  1  ray hit a block
- in_dir  in  2  face hit: 0 x, 1 y, 2 z, 3 reserved
- in_mat_rgb  in  3*COLOR_W  material colour
- in_t  in  T_W  hit distance
- in_tag  in  TAG_W  pixel tag
- out_valid  out  1  output pixel valid
- out_ready  in  1  consumer accepts
- out_rgb  out  3*COLOR_W  shaded colour
- out_tag  out  TAG_W  tag of out_rgb
- clear_in  in  1  synchronous clear of statistics
- hit_count, miss_count  out  CNT_W  saturating counts of accepted hits/misses

## Operation
- Transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
- Global advance enable en = !out_valid || out_ready; in_ready = en. All three stages shift together when en=1; otherwise hold.
- S1: register inputs and mode. Compute fog weight f = min(in_t >> FOG_SHIFT, 255). Look up face factor k: dir0 256, dir1 192, dir2 128, dir3 256.
- S2: per channel, c' = (c*k)>>8 for modes 1,2; c' = c for modes 0,3.
- S3: mode 2: c'' = (c'*(256-f) + fog*f)>>8. Mode 3: all channels = 255-f. Modes 0,1: c'' = c'.
- Miss (in_hit=0): out_rgb = sky_rgb_in captured at S1, for modes 0-2; mode 3 gives 0.
- Arithmetic: unsigned, truncating. Intermediates are COLOR_W+9 bits. Results never exceed 2^COLOR_W-1, so no clamp is needed.
- Mode, fog colour and sky colour are captured per pixel at S1. Changing them mid-stream never alters pixels already in flight.
- Statistics:
  - hit_count increments on accepted hits; miss_count on accepted misses.
  - Both saturate at all-ones.
  - clear_in zeroes both. Clear wins over a simultaneous increment.

## Timing
- Latency 3 cycles, accept to out_valid, with no stall. Throughput 1 pixel/cycle.
- Capacity 3 pixels; order strictly preserved.
- in_ready combinationally depends on out_valid/out_ready. Upstream must not make in_valid depend on in_ready.
- While out_valid=1 and out_ready=0: out_rgb and out_tag hold stable and no stage moves.
- Reset values: all stage valids 0, out_valid 0, out_rgb 0, out_tag 0, hit_count 0, miss_count 0. in_ready is 1 after reset.
- Reset asserted mid-operation discards in-flight pixels immediately. Nothing is emitted for them after release.

## Structure
- Package pixel_shade_pkg:
  - mode enum (SHADE_FLAT, SHADE_FACE, SHADE_FOG, SHADE_DEPTH)
  - face-factor constants FACE_K_X/Y/Z
  - rgb struct helper parameterised on COLOR_W
- One sub-module, shade_blend_ch: single-channel S2/S3 datapath (face multiply plus fog blend). Instantiated three times.

## Test plan
- Flat: mode 0, hit, mat (200,100,50), dir 1 -> out (200,100,50) exactly 3 cycles after accept; tag preserved.
- Face: mode 1, dir 2, mat (200,100,50) -> (100,50,25). Dir 1 -> (150,75,37).
- Fog: mode 2, dir 0, mat (200,100,50), t=0x0800 (f=128), fog (255,255,255) -> (227,177,152). t=0xFFFF -> f=255 -> (254,254,254).
- Miss/depth: hit=0, sky (10,20,30) in mode 2 -> (10,20,30), miss_count+1. Mode 3, hit, t=0x0100 -> (239,239,239).
- Backpressure: 6 back-to-back pixels, out_ready low cycles 4-8.
  - in_ready drops while stalled; no pixel is lost or duplicated.
  - Output order matches tags; out_rgb is stable during the stall.
- Reset/stats:
  - 5 hits + 2 misses -> counts 5/2.
  - clear_in coincident with a hit -> 0/0.
  - Async rst_in pulse with 3 pixels in flight -> out_valid 0 immediately, no stale output after release.
